hazard_tag_pipe: RTL and testbench
==================================

Name: hazard_tag_pipe

Overview:
- Producer side of the operand-forwarding interface.
- Carries register-tag and control state (RS/RT/RD, RegWrite, MemRead) from ID through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Drives the IDEX_RS/RT, EXMEM_RegWrite/RD and MEMWB_RegWrite/RD tags consumed by forwarding logic.
- Detects load-use hazards, inserts bubbles, applies branch flush, freezes on data-memory wait, and counts inserted bubbles.

Parameters:
CNT_W, 16, width of the saturating bubble counter StallCount_o
ZERO_REG, 0, register index that is never a hazard source (hard-wired $zero)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
ID_RS_i  in  5  source register 1 of the instruction in ID
ID_RT_i  in  5  source register 2 of the instruction in ID
ID_RD_i  in  5  destination register of the instruction in ID (already RT/RD-muxed)
ID_RegWrite_i  in  1  instruction in ID writes the register file
ID_MemRead_i  in  1  instruction in ID is a load
Flush_i  in  1  squash the instruction in ID (taken branch/jump)
MemReady_i  in  1  data memory ready; 0 freezes the whole pipeline
IDEX_RS_o  out  5  ID/EX source register 1
IDEX_RT_o  out  5  ID/EX source register 2
IDEX_RD_o  out  5  ID/EX destination register
IDEX_RegWrite_o  out  1  ID/EX register write enable
IDEX_MemRead_o  out  1  ID/EX load flag
EXMEM_RegWrite_o  out  1  EX/MEM register write enable
EXMEM_RD_o  out  5  EX/MEM destination register
MEMWB_RegWrite_o  out  1  MEM/WB register write enable
MEMWB_RD_o  out  5  MEM/WB destination register
Stall_o  out  1  hold PC and IF/ID this cycle
StallCount_o  out  CNT_W  number of load-use bubbles inserted, saturating

Behaviour:
- Reset (rst_i=0, asynchronous): every registered output is 0; StallCount_o=0. The pipeline holds only bubbles.
- Bubble definition: RS=RT=RD=0, RegWrite=0, MemRead=0.
- Hazard (combinational): IDEX_MemRead_o=1, IDEX_RD_o!=ZERO_REG, and (IDEX_RD_o==ID_RS_i or IDEX_RD_o==ID_RT_i).
- Stall_o = hazard OR (MemReady_i==0). It is combinational and has no registered latency.
- Per-edge priority, highest first:
  1. MemReady_i=0 (freeze): all stage registers hold. Counter holds. Flush_i is ignored and must be held by the source until the freeze ends.
  2. Hazard: ID/EX loads a bubble. EX/MEM<-ID/EX and MEM/WB<-EX/MEM advance. Counter increments. Flush_i is ignored this cycle because IF/ID is held and the branch re-resolves next cycle.
  3. Flush_i=1: ID/EX loads a bubble. Later stages advance. Counter unchanged.
  4. Otherwise: ID/EX<-ID inputs, EX/MEM<-ID/EX, MEM/WB<-EX/MEM.
- Latency: an ID tag appears on IDEX_* 1 cycle later, EXMEM_* 2 cycles later and MEMWB_* 3 cycles later, each plus any freeze/stall cycles.
- RD=0 with RegWrite=1 propagates unmodified. Filtering RD=0 is the consumer's job; the hazard check alone excludes ZERO_REG.
- A load followed by a dependent instruction produces exactly one bubble. On the next cycle the load is in EX/MEM and hazard is false, because IDEX now holds the bubble.
- A hazard on both RS and RT in the same cycle is one hazard: one bubble, counter +1.
- Counter saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-stall or mid-freeze clears everything immediately. Stall_o is 0 while in reset, since IDEX_MemRead_o=0, unless MemReady_i=0.

Test Plan:
- Reset, then 4 independent ALU ops with RD=1,2,3,4, RegWrite=1, MemReady_i=1 -> RD=1 on EXMEM_RD_o at edge 2 and on MEMWB_RD_o at edge 3; Stall_o stays 0; StallCount_o=0.
- Load RD=5, then an op with RS=5 -> Stall_o=1 for exactly 1 cycle; IDEX holds a bubble next; the load's RD=5 reaches EXMEM then MEMWB in order; StallCount_o=1.
- Load RD=0, then an op with RS=0 -> no stall; StallCount_o=0.
- Load RD=7, then an op with RS=7, RT=7, with Flush_i=1 in the same cycle -> one bubble, StallCount_o=1, Flush_i ignored. Flush re-asserted next cycle -> a second bubble, counter still 1.
- MemReady_i=0 for 3 cycles with the pipeline full -> all outputs frozen, Stall_o=1 each cycle, no counter change. Resumes cleanly on MemReady_i=1.
- CNT_W=2 with 5 load-use pairs -> StallCount_o=3 (saturated). Pulse rst_i=0 mid-stall -> all outputs 0 asynchronously before the next edge.

Source files
------------

// File: rtl/hazard_tag_pipe.sv
// Register-tag and control pipeline (ID/EX, EX/MEM, MEM/WB) feeding the forwarding unit,
// with load-use bubble insertion, branch flush, memory-wait freeze and a saturating bubble count.
module hazard_tag_pipe #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [4:0]  ZERO_REG = 5'd0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RS_i,
  input  logic [4:0]       ID_RT_i,
  input  logic [4:0]       ID_RD_i,
  input  logic             ID_RegWrite_i,
  input  logic             ID_MemRead_i,
  input  logic             Flush_i,
  input  logic             MemReady_i,
  output logic [4:0]       IDEX_RS_o,
  output logic [4:0]       IDEX_RT_o,
  output logic [4:0]       IDEX_RD_o,
  output logic             IDEX_RegWrite_o,
  output logic             IDEX_MemRead_o,
  output logic             EXMEM_RegWrite_o,
  output logic [4:0]       EXMEM_RD_o,
  output logic             MEMWB_RegWrite_o,
  output logic [4:0]       MEMWB_RD_o,
  output logic             Stall_o,
  output logic [CNT_W-1:0] StallCount_o
);

  logic [4:0]       idex_rs, idex_rt, idex_rd;
  logic             idex_rw, idex_mr;
  logic [4:0]       exmem_rd, memwb_rd;
  logic             exmem_rw, memwb_rw;
  logic [CNT_W-1:0] stall_count;
  logic             hazard;
  logic             bubble;

  always_comb begin
    hazard = idex_mr && (idex_rd != ZERO_REG) &&
             ((idex_rd == ID_RS_i) || (idex_rd == ID_RT_i));
    bubble = hazard || Flush_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_rs     <= '0;
      idex_rt     <= '0;
      idex_rd     <= '0;
      idex_rw     <= 1'b0;
      idex_mr     <= 1'b0;
      exmem_rd    <= '0;
      exmem_rw    <= 1'b0;
      memwb_rd    <= '0;
      memwb_rw    <= 1'b0;
      stall_count <= '0;
    end else if (MemReady_i) begin
      exmem_rd <= idex_rd;
      exmem_rw <= idex_rw;
      memwb_rd <= exmem_rd;
      memwb_rw <= exmem_rw;
      // Hazard and flush both squash into ID/EX; only the hazard is counted.
      if (bubble) begin
        idex_rs <= '0;
        idex_rt <= '0;
        idex_rd <= '0;
        idex_rw <= 1'b0;
        idex_mr <= 1'b0;
      end else begin
        idex_rs <= ID_RS_i;
        idex_rt <= ID_RT_i;
        idex_rd <= ID_RD_i;
        idex_rw <= ID_RegWrite_i;
        idex_mr <= ID_MemRead_i;
      end
      if (hazard && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  always_comb begin
    IDEX_RS_o        = idex_rs;
    IDEX_RT_o        = idex_rt;
    IDEX_RD_o        = idex_rd;
    IDEX_RegWrite_o  = idex_rw;
    IDEX_MemRead_o   = idex_mr;
    EXMEM_RegWrite_o = exmem_rw;
    EXMEM_RD_o       = exmem_rd;
    MEMWB_RegWrite_o = memwb_rw;
    MEMWB_RD_o       = memwb_rd;
    Stall_o          = hazard || !MemReady_i;
    StallCount_o     = stall_count;
  end

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Directed bench for hazard_tag_pipe: a list-of-stages model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_hazard_tag_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_rw = 1'b0, id_mr = 1'b0, flush = 1'b0, ready = 1'b1;

  logic [4:0]  idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic        idex_rw, idex_mr, exmem_rw, memwb_rw, stall;
  logic [15:0] count;

  logic [4:0]  s_idex_rs, s_idex_rt, s_idex_rd, s_exmem_rd, s_memwb_rd;
  logic        s_idex_rw, s_idex_mr, s_exmem_rw, s_memwb_rw, s_stall;
  logic [1:0]  s_count;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hazard_tag_pipe dut (
    .clk_i(clk), .rst_i(rst_n),
    .ID_RS_i(id_rs), .ID_RT_i(id_rt), .ID_RD_i(id_rd),
    .ID_RegWrite_i(id_rw), .ID_MemRead_i(id_mr),
    .Flush_i(flush), .MemReady_i(ready),
    .IDEX_RS_o(idex_rs), .IDEX_RT_o(idex_rt), .IDEX_RD_o(idex_rd),
    .IDEX_RegWrite_o(idex_rw), .IDEX_MemRead_o(idex_mr),
    .EXMEM_RegWrite_o(exmem_rw), .EXMEM_RD_o(exmem_rd),
    .MEMWB_RegWrite_o(memwb_rw), .MEMWB_RD_o(memwb_rd),
    .Stall_o(stall), .StallCount_o(count)
  );

  hazard_tag_pipe #(.CNT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst_n),
    .ID_RS_i(id_rs), .ID_RT_i(id_rt), .ID_RD_i(id_rd),
    .ID_RegWrite_i(id_rw), .ID_MemRead_i(id_mr),
    .Flush_i(flush), .MemReady_i(ready),
    .IDEX_RS_o(s_idex_rs), .IDEX_RT_o(s_idex_rt), .IDEX_RD_o(s_idex_rd),
    .IDEX_RegWrite_o(s_idex_rw), .IDEX_MemRead_o(s_idex_mr),
    .EXMEM_RegWrite_o(s_exmem_rw), .EXMEM_RD_o(s_exmem_rd),
    .MEMWB_RegWrite_o(s_memwb_rw), .MEMWB_RD_o(s_memwb_rd),
    .Stall_o(s_stall), .StallCount_o(s_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pipe[0]=ID/EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB
  typedef struct {
    int rs, rt, rd, rw, mr;
  } tag_t;
  tag_t pipe[3];
  int   m_cnt = 0;
  int   m_cnt_s = 0;

  function automatic bit m_hazard();
    return pipe[0].mr == 1 && pipe[0].rd != 0 &&
           (pipe[0].rd == int'(id_rs) || pipe[0].rd == int'(id_rt));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0, 0};
      m_cnt = 0;
      m_cnt_s = 0;
    end else if (ready) begin
      bit h;
      h = m_hazard();
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (h || flush) pipe[0] = '{0, 0, 0, 0, 0};
      else pipe[0] = '{int'(id_rs), int'(id_rt), int'(id_rd), int'(id_rw), int'(id_mr)};
      if (h) begin
        m_cnt   = (m_cnt   < 65535) ? m_cnt + 1   : m_cnt;
        m_cnt_s = (m_cnt_s < 3)     ? m_cnt_s + 1 : m_cnt_s;
      end
    end
  end

  always @(negedge clk) begin
    chk("idex_rs",  32'(idex_rs),  32'(pipe[0].rs));
    chk("idex_rt",  32'(idex_rt),  32'(pipe[0].rt));
    chk("idex_rd",  32'(idex_rd),  32'(pipe[0].rd));
    chk("idex_rw",  32'(idex_rw),  32'(pipe[0].rw));
    chk("idex_mr",  32'(idex_mr),  32'(pipe[0].mr));
    chk("exmem_rd", 32'(exmem_rd), 32'(pipe[1].rd));
    chk("exmem_rw", 32'(exmem_rw), 32'(pipe[1].rw));
    chk("memwb_rd", 32'(memwb_rd), 32'(pipe[2].rd));
    chk("memwb_rw", 32'(memwb_rw), 32'(pipe[2].rw));
    chk("stall",    32'(stall),    32'(m_hazard() || !ready));
    chk("count",    32'(count),    32'(m_cnt));
    chk("s_stall",  32'(s_stall),  32'(m_hazard() || !ready));
    chk("s_memwb_rd", 32'(s_memwb_rd), 32'(pipe[2].rd));
    chk("s_count",  32'(s_count),  32'(m_cnt_s));
  end

  task automatic set_id(input int rs, input int rt, input int rd, input bit rw, input bit mr);
    id_rs = 5'(rs);
    id_rt = 5'(rt);
    id_rd = 5'(rd);
    id_rw = rw;
    id_mr = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_id(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_idex_rd", 32'(idex_rd), 0);
    chk("rst_memwb_rw", 32'(memwb_rw), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_count", 32'(count), 0);
    rst_n = 1'b1;

    // Independent ALU ops
    for (int i = 1; i <= 4; i++) begin
      set_id(i + 10, i + 20, i, 1, 0);
      chk("alu_stall", 32'(stall), 0);
      tick();
      if (i == 2) chk("alu_exmem_rd", 32'(exmem_rd), 1);
      if (i == 3) chk("alu_memwb_rd", 32'(memwb_rd), 1);
    end
    chk("alu_count", 32'(count), 0);

    // Load then dependent op on RS
    set_id(0, 0, 5, 1, 1);
    tick();
    set_id(5, 6, 8, 1, 0);
    chk("lu_stall", 32'(stall), 1);
    tick();
    chk("lu_bubble_rd", 32'(idex_rd), 0);
    chk("lu_bubble_mr", 32'(idex_mr), 0);
    chk("lu_exmem_rd", 32'(exmem_rd), 5);
    chk("lu_count", 32'(count), 1);
    chk("lu_stall_gone", 32'(stall), 0);
    tick();
    chk("lu_idex_rd", 32'(idex_rd), 8);
    chk("lu_memwb_rd", 32'(memwb_rd), 5);

    // Load to $zero never stalls
    set_id(0, 0, 0, 1, 1);
    tick();
    set_id(0, 0, 9, 1, 0);
    chk("zero_stall", 32'(stall), 0);
    tick();
    chk("zero_count", 32'(count), 1);
    chk("zero_idex_rd", 32'(idex_rd), 9);

    // Double-source hazard with a concurrent flush
    set_id(0, 0, 7, 1, 1);
    tick();
    set_id(7, 7, 10, 1, 0);
    flush = 1'b1;
    #1;
    chk("dbl_stall", 32'(stall), 1);
    tick();
    chk("dbl_idex_rd", 32'(idex_rd), 0);
    chk("dbl_count", 32'(count), 2);
    chk("dbl_stall_gone", 32'(stall), 0);
    tick();
    chk("flush_idex_rd", 32'(idex_rd), 0);
    chk("flush_idex_rw", 32'(idex_rw), 0);
    chk("flush_count", 32'(count), 2);
    flush = 1'b0;

    // Memory wait freeze with a full pipeline
    for (int i = 11; i <= 13; i++) begin
      set_id(0, 0, i, 1, 0);
      tick();
    end
    set_id(0, 0, 14, 1, 0);
    ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("frz_stall", 32'(stall), 1);
      tick();
      chk("frz_idex_rd", 32'(idex_rd), 13);
      chk("frz_exmem_rd", 32'(exmem_rd), 12);
      chk("frz_memwb_rd", 32'(memwb_rd), 11);
      chk("frz_count", 32'(count), 2);
    end
    ready = 1'b1;
    #1;
    chk("frz_resume_stall", 32'(stall), 0);
    tick();
    chk("res_idex_rd", 32'(idex_rd), 14);
    chk("res_exmem_rd", 32'(exmem_rd), 13);
    chk("res_memwb_rd", 32'(memwb_rd), 12);

    // Five load-use pairs, alternating RS and RT dependence
    for (int k = 0; k < 5; k++) begin
      set_id(0, 0, 20 + k, 1, 1);
      tick();
      if (k % 2 == 0) set_id(20 + k, 0, 0, 0, 0);
      else set_id(0, 20 + k, 0, 0, 0);
      chk("sat_stall", 32'(stall), 1);
      tick();
      tick();
    end
    chk("sat_count_big", 32'(count), 7);
    chk("sat_count_small", 32'(s_count), 3);

    // Asynchronous reset in the middle of a stall
    set_id(0, 0, 3, 1, 1);
    tick();
    set_id(3, 0, 0, 0, 0);
    chk("ar_stall_pre", 32'(stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_idex_rd", 32'(idex_rd), 0);
    chk("ar_idex_mr", 32'(idex_mr), 0);
    chk("ar_exmem_rd", 32'(exmem_rd), 0);
    chk("ar_memwb_rd", 32'(memwb_rd), 0);
    chk("ar_stall", 32'(stall), 0);
    chk("ar_count", 32'(count), 0);
    chk("ar_s_count", 32'(s_count), 0);
    ready = 1'b0;
    #1;
    chk("ar_stall_wait", 32'(stall), 1);
    ready = 1'b1;
    set_id(0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
